// File: rtl/clk_reset_pkg.sv
// Shared types and constants for the clock-enable / reset sequencer.
// Holds the FSM state enum, the divider phase constants and the default sound increment.
package clk_reset_pkg;

    typedef enum logic [1:0] {
        RESET     = 2'd0,
        WAIT_LOCK = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [3:0] DIV_TOP    = 4'd11;
    localparam logic [3:0] PIX_PHASE0 = 4'd5;
    localparam logic [3:0] PIX_PHASE1 = 4'd11;
    localparam logic [3:0] CPU_PHASE  = 4'd11;

    // 3.579545 / 36.868686 * 65536
    localparam logic [15:0] DEF_SND_PHASE_INC = 16'd6363;

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous level, async active-high reset.
// Ports: clk, rst (async, active-high), d (async input), q (synchronized output).
module bit_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_reset_seq.sv
// Reset sequencer and phase-aligned clock-enable generator behind the core PLL.
// Waits for PLL lock, holds sys_reset for HOLD_CYCLES, then emits ce_pix (/6),
// ce_cpu (/12) and ce_snd. Counts lock drops seen while running.
// Ports: clk, rst (async, active-high), pll_locked (async), soft_rst (sync level),
//        sys_reset, ce_pix, ce_cpu, ce_snd, lock_loss_cnt[3:0].
// Build option: define CLK_RESET_SEQ_SND_FRAC_EN for a fractional phase-accumulator
// sound enable; otherwise ce_snd is a plain divide-by-SND_DIV.
module clk_reset_seq
    import clk_reset_pkg::*;
#(
    parameter int unsigned  HOLD_CYCLES   = 1024,
    parameter logic [15:0]  SND_PHASE_INC = DEF_SND_PHASE_INC,
    parameter int unsigned  SND_DIV       = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_rst,
    output logic       sys_reset,
    output logic       ce_pix,
    output logic       ce_cpu,
    output logic       ce_snd,
    output logic [3:0] lock_loss_cnt
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic        lock_s;
    logic [15:0] hold_cnt;
    logic [3:0]  div_cnt;
    logic        run_stay;
    logic        snd_hit;

    bit_sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; lock loss outranks soft reset
    always_comb begin
        next_state = state;
        unique case (state)
            RESET: begin
                next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    next_state = WAIT_LOCK;
                end else if (soft_rst) begin
                    next_state = HOLD;
                end else if (hold_cnt == HOLD_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    next_state = WAIT_LOCK;
                end else if (soft_rst) begin
                    next_state = HOLD;
                end
            end
            default: begin
                next_state = RESET;
            end
        endcase
    end

    // Counters only advance while the state is stable in RUN, so every
    // entry into RUN starts them from zero.
    assign run_stay = (state == RUN) && (next_state == RUN);

    // Registered from next_state so sys_reset is glitch-free and
    // drops on the same edge the FSM enters RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sys_reset <= 1'b1;
        end else begin
            sys_reset <= (next_state != RUN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state == HOLD && next_state == HOLD && !soft_rst) begin
            hold_cnt <= hold_cnt + 16'd1;
        end else begin
            hold_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (run_stay) begin
            div_cnt <= (div_cnt == DIV_TOP) ? 4'd0 : div_cnt + 4'd1;
        end else begin
            div_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_loss_cnt <= '0;
        end else if (state == RUN && next_state == WAIT_LOCK
                     && lock_loss_cnt != 4'hF) begin
            lock_loss_cnt <= lock_loss_cnt + 4'd1;
        end
    end

`ifdef CLK_RESET_SEQ_SND_FRAC_EN
    logic [15:0] snd_acc;
    logic [16:0] snd_sum;
    logic        unused_snd_div;

    assign snd_sum        = {1'b0, snd_acc} + {1'b0, SND_PHASE_INC};
    assign snd_hit        = snd_sum[16];
    assign unused_snd_div = ^SND_DIV;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snd_acc <= '0;
        end else if (run_stay) begin
            snd_acc <= snd_sum[15:0];
        end else begin
            snd_acc <= '0;
        end
    end
`else
    localparam logic [15:0] SND_LAST = 16'(SND_DIV - 1);

    logic [15:0] snd_cnt;
    logic        unused_snd_inc;

    assign snd_hit        = (snd_cnt == SND_LAST);
    assign unused_snd_inc = ^SND_PHASE_INC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snd_cnt <= '0;
        end else if (run_stay) begin
            snd_cnt <= snd_hit ? 16'd0 : snd_cnt + 16'd1;
        end else begin
            snd_cnt <= '0;
        end
    end
`endif

    // Enables decoded from divider phase, gated off while in reset
    always_comb begin
        ce_pix = 1'b0;
        ce_cpu = 1'b0;
        ce_snd = 1'b0;
        if (!sys_reset) begin
            ce_pix = (div_cnt == PIX_PHASE0) || (div_cnt == PIX_PHASE1);
            ce_cpu = (div_cnt == CPU_PHASE);
            ce_snd = snd_hit;
        end
    end

endmodule

// File: tb/tb_clk_reset_seq.sv
// Self-checking bench for clk_reset_seq with HOLD_CYCLES = 16.
// Table of release-sequence expectations fed through a time-stamped scoreboard.
`timescale 1ns/1ps
module tb_clk_reset_seq;
    import clk_reset_pkg::*;

    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b1;
    logic       soft_rst = 1'b0;
    logic       sys_reset;
    logic       ce_pix;
    logic       ce_cpu;
    logic       ce_snd;
    logic [3:0] lock_loss_cnt;

    clk_reset_seq #(.HOLD_CYCLES(HOLD)) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .soft_rst      (soft_rst),
        .sys_reset     (sys_reset),
        .ce_pix        (ce_pix),
        .ce_cpu        (ce_cpu),
        .ce_snd        (ce_snd),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   at;
        logic srst;
        logic pix;
        logic cpu;
    } row_t;

    typedef struct {
        int         at;
        logic       srst;
        logic       pix;
        logic       cpu;
        logic [3:0] llc;
        string      tag;
    } vec_t;

    row_t tbl [12];
    vec_t sb [$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    task automatic chk(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic push(input int at, input logic s, input logic p,
                        input logic c, input logic [3:0] l, input string tag);
        vec_t v;
        v.at = at; v.srst = s; v.pix = p; v.cpu = c; v.llc = l; v.tag = tag;
        sb.push_back(v);
    endtask

    // One clock, sampled 1 ns after the edge; due scoreboard entries compared
    task automatic step();
        vec_t v;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            v = sb.pop_front();
            n_vec++;
            if (v.at != cyc ||
                {sys_reset, ce_pix, ce_cpu, lock_loss_cnt} !=
                {v.srst, v.pix, v.cpu, v.llc}) begin
                n_miss++;
                $display("FAIL %s @%0d: got srst=%b pix=%b cpu=%b llc=%0d expected srst=%b pix=%b cpu=%b llc=%0d",
                         v.tag, cyc, sys_reset, ce_pix, ce_cpu, lock_loss_cnt,
                         v.srst, v.pix, v.cpu, v.llc);
            end
        end
    endtask

    // Release sequence relative to the cycle the lock (or rst release) is applied
    task automatic apply_tbl(input int base, input logic [3:0] llc, input string tag);
        for (int i = 0; i < 12; i++) begin
            push(base + tbl[i].at, tbl[i].srst, tbl[i].pix, tbl[i].cpu, llc,
                 $sformatf("%s_t%0d", tag, tbl[i].at));
        end
    endtask

    task automatic wait_srst(input logic want, input int max, input string tag);
        for (int n = 0; n < max; n++) begin
            if (sys_reset == want) break;
            step();
        end
        chk(tag, int'(sys_reset), int'(want));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int d;
        int np;
        int nc;
        int ns;
        int bad;
        int snd_exp;

        tbl = '{
            '{1,  1'b1, 1'b0, 1'b0},
            '{3,  1'b1, 1'b0, 1'b0},
            '{18, 1'b1, 1'b0, 1'b0},
            '{19, 1'b0, 1'b0, 1'b0},
            '{23, 1'b0, 1'b0, 1'b0},
            '{24, 1'b0, 1'b1, 1'b0},
            '{25, 1'b0, 1'b0, 1'b0},
            '{30, 1'b0, 1'b1, 1'b1},
            '{31, 1'b0, 1'b0, 1'b0},
            '{36, 1'b0, 1'b1, 1'b0},
            '{41, 1'b0, 1'b0, 1'b0},
            '{42, 1'b0, 1'b1, 1'b1}
        };

        // Reset state with lock already present
        repeat (3) step();
        chk("rst_srst", int'(sys_reset), 1);
        chk("rst_pix", int'(ce_pix), 0);
        chk("rst_cpu", int'(ce_cpu), 0);
        chk("rst_snd", int'(ce_snd), 0);
        chk("rst_llc", int'(lock_loss_cnt), 0);

        // Startup: RUN cycle 0 at release+19
        rst = 1'b0;
        base = cyc;
        apply_tbl(base, 4'd0, "start");
        repeat (45) step();

        // Lock loss mid-RUN (RUN cycle 26)
        pll_locked = 1'b0;
        d = cyc;
        push(d + 2, 1'b0, 1'b0, 1'b0, 4'd0, "drop_e2");
        push(d + 3, 1'b1, 1'b0, 1'b0, 4'd1, "drop_e3");
        repeat (20) step();
        pll_locked = 1'b1;
        base = cyc;
        apply_tbl(base, 4'd1, "relock");
        repeat (45) step();

        // One-cycle soft reset in RUN
        soft_rst = 1'b1;
        d = cyc;
        push(d + 1,  1'b1, 1'b0, 1'b0, 4'd1, "soft_e1");
        push(d + 16, 1'b1, 1'b0, 1'b0, 4'd1, "soft_e16");
        push(d + 17, 1'b0, 1'b0, 1'b0, 4'd1, "soft_e17");
        push(d + 22, 1'b0, 1'b1, 1'b0, 4'd1, "soft_pix");
        push(d + 28, 1'b0, 1'b1, 1'b1, 4'd1, "soft_cpu");
        step();
        soft_rst = 1'b0;
        repeat (29) step();

        // soft_rst coincides with lock_s falling
        pll_locked = 1'b0;
        d = cyc;
        step();
        step();
        soft_rst = 1'b1;
        push(d + 3, 1'b1, 1'b0, 1'b0, 4'd2, "simul_e3");
        step();
        soft_rst = 1'b0;
        chk("simul_state", int'(dut.state), int'(WAIT_LOCK));
        repeat (5) step();
        chk("simul_state_hold", int'(dut.state), int'(WAIT_LOCK));
        pll_locked = 1'b1;
        wait_srst(1'b0, 40, "simul_relock");

        // Rate over 65536 RUN cycles starting at RUN cycle 0
`ifdef CLK_RESET_SEQ_SND_FRAC_EN
        snd_exp = 6363;
`else
        snd_exp = 6553;
`endif
        np = 0; nc = 0; ns = 0; bad = 0;
        for (int i = 0; i < 65536; i++) begin
            if (i != 0) step();
            np += int'(ce_pix);
            nc += int'(ce_cpu);
            ns += int'(ce_snd);
            if (ce_cpu && !ce_pix) bad++;
            if (sys_reset) bad++;
        end
        chk("rate_pix", np, 10922);
        chk("rate_cpu", nc, 5461);
        chk("rate_snd", ns, snd_exp);
        chk("rate_align", bad, 0);

        // 15 more drops, 17 total; counter saturates at 15
        for (int k = 0; k < 15; k++) begin
            pll_locked = 1'b0;
            repeat (4) step();
            pll_locked = 1'b1;
            wait_srst(1'b0, 40, $sformatf("sat_relock%0d", k));
            if (k == 9) chk("llc_12", int'(lock_loss_cnt), 12);
        end
        chk("llc_sat", int'(lock_loss_cnt), 15);

        // Async reset between edges, right after a pixel pulse
        for (int n = 0; n < 20; n++) begin
            if (ce_pix) break;
            step();
        end
        chk("async_pre_pix", int'(ce_pix), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_srst", int'(sys_reset), 1);
        chk("async_pix", int'(ce_pix), 0);
        chk("async_cpu", int'(ce_cpu), 0);
        chk("async_snd", int'(ce_snd), 0);
        chk("async_llc", int'(lock_loss_cnt), 0);
        chk("async_state", int'(dut.state), int'(RESET));
        repeat (2) step();
        rst = 1'b0;

        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard: %0d entries never compared, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
